ysyx_22050499_sram_arbiter: RTL and testbench
=============================================

Name: ysyx_22050499_sram_arbiter

Overview:
- Two-master, one-slave AXI4-Lite arbiter placed in front of the on-chip SRAM slave.
- Master 0 is the IFU, which issues reads only. Master 1 is the LSU, which issues reads and writes.
- Grants ownership of the single SRAM port to one master per transaction, with round-robin on ties and one outstanding transaction.
- A watchdog converts a hung slave response into an error response (SLVERR) so the core cannot deadlock.

Parameters:
- ADDR_W, 32, address width of every AR/AW channel.
- DATA_W, 32, data width; WSTRB width is DATA_W/8.
- TIMEOUT, 255, number of cycles a granted transaction may stay open before the watchdog aborts it; minimum legal value is 4.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ifu_arvalid/ifu_arready  in/out  1  IFU read-address handshake.
- ifu_araddr  in  ADDR_W  IFU read address.
- ifu_rvalid/ifu_rready  out/in  1  IFU read-data handshake.
- ifu_rdata  out  DATA_W  IFU read data.
- ifu_rresp  out  2  IFU read response.
- lsu_arvalid/lsu_arready, lsu_araddr, lsu_rvalid/lsu_rready, lsu_rdata, lsu_rresp: same as the IFU read ports, for the LSU.
- lsu_awvalid/lsu_awready  in/out  1  LSU write-address handshake.
- lsu_awaddr  in  ADDR_W  LSU write address.
- lsu_wvalid/lsu_wready  in/out  1  LSU write-data handshake.
- lsu_wdata  in  DATA_W  LSU write data.
- lsu_wstrb  in  DATA_W/8  LSU write strobes.
- lsu_bvalid/lsu_bready  out/in  1  LSU write-response handshake.
- lsu_bresp  out  2  LSU write response.
- s_ar*, s_r*, s_aw*, s_w*, s_b*: the same channel set toward the SRAM, with directions mirrored.
- grant  out  2  current owner: 00 none, 01 IFU, 10 LSU.
- timeout_err  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, last_owner=IFU, watchdog=0, grant=00, timeout_err=0.
  - Every valid and ready output to masters and slave is 0.
- States: IDLE, IFU_RD, LSU_RD, LSU_WR, ERR.
- IDLE arbitration:
  - ifu_req=ifu_arvalid; lsu_req=lsu_arvalid|lsu_awvalid.
  - Only one request present: grant it.
  - Both present: grant the master that is not last_owner. After reset the LSU wins the first tie.
  - An LSU holding both AR and AW goes to LSU_WR first.
  - The grant decision is registered: the slave sees the forwarded valid no earlier than the cycle after the request appears in IDLE.
  - In IDLE every master ready is 0. s_rready=1 and s_bready=1 so stale slave responses are drained and dropped.
- Forwarding in a grant state:
  - The owner's channel signals pass combinationally to the slave and back.
  - The non-owner sees arready/awready/wready/rvalid/bvalid = 0.
  - Slave valid signals are driven only from the owner.
- Read states (IFU_RD, LSU_RD):
  - Forward AR until the s_arvalid & s_arready handshake, then set ar_done and force s_arvalid=0.
  - Forward R; on the owner's rvalid & rready handshake, go to IDLE and update last_owner.
- LSU_WR:
  - AW and W are forwarded independently and each is blocked after its own handshake (aw_done, w_done). They may complete in either order or in the same cycle.
  - B is forwarded. On bvalid & bready, go to IDLE and update last_owner.
- Owner-side request changes:
  - Dropping a request after the grant does not cancel the transaction. AXI rules require the valid to be held anyway.
  - New requests from either master wait; their ready stays 0.
- Watchdog:
  - Cleared on entering a grant state and incremented every cycle spent in it.
  - When the count reaches TIMEOUT, pulse timeout_err, force all slave valids to 0, and go to ERR.
- ERR state:
  - Drive the owner's rvalid (or bvalid) = 1 with resp=2'b10 and rdata=0.
  - On the owner's ready, go to IDLE.
  - If AR/AW/W had not yet been accepted, the owner's pending ready is asserted for one cycle in ERR to retire it.
- Throughput:
  - Minimum latency is 3 cycles per transaction: arbitration, address handshake, response.
  - There is no back-to-back grant. IDLE always lasts at least one cycle between transactions.
- Reset mid-transaction returns to IDLE immediately. Slave-side recovery is the slave's own responsibility under the same reset.

Test Plan:
- IFU read: IFU reads 0x8000_0010; slave returns 0x1234_5678 with arready/rvalid each after 1 cycle → ifu_rdata=0x12345678, rresp=00, grant=01 then 00, LSU sees no handshake.
- Simultaneous reads: after reset, IFU and LSU both assert arvalid on the same cycle → LSU served first, then IFU. A second simultaneous pair is served IFU first.
- LSU write, W before AW: wdata=0xDEADBEEF, wstrb=0x3, W valid 2 cycles before AW → slave sees exactly one AW and one W handshake; lsu_bresp=00; grant returns to 00.
- LSU with both AR and AW pending: write completes fully before the read's AR is forwarded.
- Watchdog: TIMEOUT=8, slave never asserts rvalid → timeout_err pulses at cycle 8 in IFU_RD; ifu_rvalid=1 with rresp=10 and rdata=0; the next IFU request is granted normally.
- Reset mid-transaction: reset=0 while in LSU_WR after AW accepted → every valid/ready output is 0 and grant=00 immediately. After release the first tie is again won by the LSU.

Source files
------------

// File: rtl/ysyx_22050499_sram_arbiter_if.sv
// AXI4-Lite channel bundle shared by the IFU, LSU and SRAM sides of the arbiter.
interface ysyx_22050499_sram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    modport master (
        output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
    );

    modport slave (
        input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
        output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/ysyx_22050499_sram_arbiter.sv
// Two-master (IFU read-only, LSU read/write) AXI4-Lite arbiter in front of the SRAM,
// one outstanding transaction, round-robin on ties, watchdog turning a hung slave into SLVERR.
module ysyx_22050499_sram_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                          clock,
    input  logic                          reset,
    ysyx_22050499_sram_arbiter_if.slave   ifu,
    ysyx_22050499_sram_arbiter_if.slave   lsu,
    ysyx_22050499_sram_arbiter_if.master  s,
    output logic [1:0]                    grant,
    output logic                          timeout_err
);
    typedef enum logic [2:0] {IDLE, IFU_RD, LSU_RD, LSU_WR, ERR} state_t;

    localparam int             WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t          r_state;
    logic            r_last_lsu;
    logic            r_err_lsu;
    logic            r_err_wr;
    logic            r_ar_done;
    logic            r_aw_done;
    logic            r_w_done;
    logic [WD_W-1:0] r_wdog;
    logic [1:0]      r_grant;
    logic            r_terr;
    logic            r_live;

    logic w_ifu_req;
    logic w_lsu_req;
    logic w_pick_lsu;
    logic w_done;
    logic w_unused_ifu;

    assign w_ifu_req    = ifu.arvalid;
    assign w_lsu_req    = lsu.arvalid | lsu.awvalid;
    assign w_pick_lsu   = w_lsu_req & (~w_ifu_req | ~r_last_lsu);
    assign grant        = r_grant;
    assign timeout_err  = r_terr;
    assign w_unused_ifu = ^{ifu.awvalid, ifu.awaddr, ifu.wvalid, ifu.wdata, ifu.wstrb, ifu.bready};

    always_comb begin
        ifu.arready = 1'b0;
        ifu.rvalid  = 1'b0;
        ifu.rdata   = {DATA_W{1'b0}};
        ifu.rresp   = 2'b00;
        ifu.awready = 1'b0;
        ifu.wready  = 1'b0;
        ifu.bvalid  = 1'b0;
        ifu.bresp   = 2'b00;
        lsu.arready = 1'b0;
        lsu.rvalid  = 1'b0;
        lsu.rdata   = {DATA_W{1'b0}};
        lsu.rresp   = 2'b00;
        lsu.awready = 1'b0;
        lsu.wready  = 1'b0;
        lsu.bvalid  = 1'b0;
        lsu.bresp   = 2'b00;
        s.arvalid   = 1'b0;
        s.araddr    = {ADDR_W{1'b0}};
        s.rready    = 1'b0;
        s.awvalid   = 1'b0;
        s.awaddr    = lsu.awaddr;
        s.wvalid    = 1'b0;
        s.wdata     = lsu.wdata;
        s.wstrb     = lsu.wstrb;
        s.bready    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                // Drain stray slave responses; held off while in reset.
                s.rready = r_live;
                s.bready = r_live;
            end
            IFU_RD: begin
                s.arvalid   = ifu.arvalid & ~r_ar_done;
                s.araddr    = ifu.araddr;
                ifu.arready = s.arready & ~r_ar_done;
                ifu.rvalid  = s.rvalid;
                ifu.rdata   = s.rdata;
                ifu.rresp   = s.rresp;
                s.rready    = ifu.rready;
                w_done      = s.rvalid & ifu.rready;
            end
            LSU_RD: begin
                s.arvalid   = lsu.arvalid & ~r_ar_done;
                s.araddr    = lsu.araddr;
                lsu.arready = s.arready & ~r_ar_done;
                lsu.rvalid  = s.rvalid;
                lsu.rdata   = s.rdata;
                lsu.rresp   = s.rresp;
                s.rready    = lsu.rready;
                w_done      = s.rvalid & lsu.rready;
            end
            LSU_WR: begin
                s.awvalid   = lsu.awvalid & ~r_aw_done;
                lsu.awready = s.awready & ~r_aw_done;
                s.wvalid    = lsu.wvalid & ~r_w_done;
                lsu.wready  = s.wready & ~r_w_done;
                lsu.bvalid  = s.bvalid;
                lsu.bresp   = s.bresp;
                s.bready    = lsu.bready;
                w_done      = s.bvalid & lsu.bready;
            end
            ERR: begin
                s.rready = r_live;
                s.bready = r_live;
                // Un-accepted address/data beats are retired by the pending ready.
                if (r_err_wr) begin
                    lsu.bvalid  = 1'b1;
                    lsu.bresp   = 2'b10;
                    lsu.awready = ~r_aw_done;
                    lsu.wready  = ~r_w_done;
                    w_done      = lsu.bready;
                end else if (r_err_lsu) begin
                    lsu.rvalid  = 1'b1;
                    lsu.rresp   = 2'b10;
                    lsu.arready = ~r_ar_done;
                    w_done      = lsu.rready;
                end else begin
                    ifu.rvalid  = 1'b1;
                    ifu.rresp   = 2'b10;
                    ifu.arready = ~r_ar_done;
                    w_done      = ifu.rready;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_last_lsu <= 1'b0;
            r_err_lsu  <= 1'b0;
            r_err_wr   <= 1'b0;
            r_ar_done  <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_wdog     <= '0;
            r_grant    <= 2'b00;
            r_terr     <= 1'b0;
            r_live     <= 1'b0;
        end else begin
            r_terr <= 1'b0;
            r_live <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_ifu_req | w_lsu_req) begin
                        r_ar_done <= 1'b0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_wdog    <= '0;
                        if (w_pick_lsu) begin
                            r_state <= lsu.awvalid ? LSU_WR : LSU_RD;
                            r_grant <= 2'b10;
                        end else begin
                            r_state <= IFU_RD;
                            r_grant <= 2'b01;
                        end
                    end
                end
                IFU_RD, LSU_RD, LSU_WR: begin
                    r_wdog <= r_wdog + WD_W'(1);
                    if (s.arvalid & s.arready) r_ar_done <= 1'b1;
                    if (s.awvalid & s.awready) r_aw_done <= 1'b1;
                    if (s.wvalid & s.wready)   r_w_done  <= 1'b1;
                    // A response completing on the last watchdog cycle still wins.
                    if (w_done) begin
                        r_state    <= IDLE;
                        r_grant    <= 2'b00;
                        r_last_lsu <= (r_state != IFU_RD);
                    end else if (r_wdog == WD_LAST) begin
                        r_state   <= ERR;
                        r_terr    <= 1'b1;
                        r_err_lsu <= (r_state != IFU_RD);
                        r_err_wr  <= (r_state == LSU_WR);
                    end
                end
                ERR: begin
                    r_ar_done <= 1'b1;
                    r_aw_done <= 1'b1;
                    r_w_done  <= 1'b1;
                    if (w_done) begin
                        r_state    <= IDLE;
                        r_grant    <= 2'b00;
                        r_last_lsu <= r_err_lsu;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22050499_sram_arbiter.sv
// Scoreboard bench for the SRAM arbiter: directed master traffic, a simple SRAM slave, and
// monitors that pop expected responses/grants as the DUT presents them.
module tb_ysyx_22050499_sram_arbiter;
    logic       clock;
    logic       reset;
    logic [1:0] grant;
    logic       timeout_err;

    ysyx_22050499_sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifu_if ();
    ysyx_22050499_sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) lsu_if ();
    ysyx_22050499_sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

    ysyx_22050499_sram_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .ifu         (ifu_if),
        .lsu         (lsu_if),
        .s           (s_if),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [33:0] q_ifu[$];
    logic [33:0] q_lsu[$];
    logic [1:0]  q_b[$];
    logic [1:0]  q_g[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    always @(posedge clock) cyc++;

    // Slave model: arready/awready/wready one cycle after valid, response the cycle after.
    bit          sl_hang = 1'b0;
    logic        sl_aw_g, sl_w_g;
    logic [31:0] sl_wdata;
    logic [3:0]  sl_wstrb;
    int          n_ar = 0, n_aw = 0, n_w = 0, n_b = 0, ar_bcnt = 0;
    logic        hs_aw, hs_w;
    assign hs_aw = s_if.awvalid & s_if.awready;
    assign hs_w  = s_if.wvalid & s_if.wready;

    function automatic logic [31:0] sl_mem(input logic [31:0] a);
        case (a)
            32'h8000_0010: return 32'h1234_5678;
            32'h8000_0020: return 32'hA5A5_0001;
            32'h8000_0030: return 32'h0BAD_CAFE;
            32'h8000_0040: return 32'h1111_2222;
            default:       return 32'hFFFF_0000;
        endcase
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            s_if.arready <= 1'b0;
            s_if.rvalid  <= 1'b0;
            s_if.rdata   <= 32'h0;
            s_if.rresp   <= 2'b00;
            s_if.awready <= 1'b0;
            s_if.wready  <= 1'b0;
            s_if.bvalid  <= 1'b0;
            s_if.bresp   <= 2'b00;
            sl_aw_g      <= 1'b0;
            sl_w_g       <= 1'b0;
        end else begin
            s_if.arready <= s_if.arvalid & ~s_if.arready;
            if (s_if.rvalid & s_if.rready) s_if.rvalid <= 1'b0;
            if (s_if.arvalid & s_if.arready) begin
                n_ar        <= n_ar + 1;
                ar_bcnt     <= n_b;
                s_if.rdata  <= sl_mem(s_if.araddr);
                s_if.rvalid <= ~sl_hang;
            end
            s_if.awready <= s_if.awvalid & ~s_if.awready & ~sl_aw_g;
            s_if.wready  <= s_if.wvalid & ~s_if.wready & ~sl_w_g;
            if (hs_aw) begin
                sl_aw_g <= 1'b1;
                n_aw    <= n_aw + 1;
            end
            if (hs_w) begin
                sl_w_g   <= 1'b1;
                n_w      <= n_w + 1;
                sl_wdata <= s_if.wdata;
                sl_wstrb <= s_if.wstrb;
            end
            if (s_if.bvalid & s_if.bready) begin
                s_if.bvalid <= 1'b0;
                n_b         <= n_b + 1;
            end
            if ((sl_aw_g | hs_aw) & (sl_w_g | hs_w)) begin
                s_if.bvalid <= 1'b1;
                sl_aw_g     <= 1'b0;
                sl_w_g      <= 1'b0;
            end
        end
    end

    // Monitors
    logic [1:0] g_prev = 2'b00;
    int t_g01 = 0, t_terr = 0, n_terr = 0, n_lsu_act = 0;
    always @(negedge clock) begin
        logic [33:0] e;
        logic [1:0]  eb;
        if (reset) begin
            if (ifu_if.rvalid && ifu_if.rready) begin
                if (q_ifu.size() == 0) chk("ifu_r_unexpected", q_ifu.size(), 1);
                else begin
                    e = q_ifu.pop_front();
                    chk("ifu_r", {ifu_if.rdata, ifu_if.rresp}, e);
                end
            end
            if (lsu_if.rvalid && lsu_if.rready) begin
                if (q_lsu.size() == 0) chk("lsu_r_unexpected", q_lsu.size(), 1);
                else begin
                    e = q_lsu.pop_front();
                    chk("lsu_r", {lsu_if.rdata, lsu_if.rresp}, e);
                end
            end
            if (lsu_if.bvalid && lsu_if.bready) begin
                if (q_b.size() == 0) chk("lsu_b_unexpected", q_b.size(), 1);
                else begin
                    eb = q_b.pop_front();
                    chk("lsu_b", lsu_if.bresp, eb);
                end
            end
            if (grant != g_prev && grant != 2'b00) begin
                if (q_g.size() == 0) chk("grant_unexpected", grant, 2'b00);
                else begin
                    eb = q_g.pop_front();
                    chk("grant_order", grant, eb);
                end
                if (grant == 2'b01) t_g01 = cyc;
            end
            if (timeout_err) begin
                n_terr++;
                t_terr = cyc;
            end
            if (lsu_if.rvalid || (lsu_if.arvalid && lsu_if.arready)) n_lsu_act++;
        end
        g_prev = grant;
    end

    task automatic ifu_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
        bit hs = 1'b0;
        int k  = 0;
        q_ifu.push_back({d, r});
        ifu_if.araddr  = a;
        ifu_if.arvalid = 1'b1;
        while (!hs && k < 60) begin
            @(negedge clock); hs = ifu_if.arready;
            @(posedge clock); #1; k++;
        end
        ifu_if.arvalid = 1'b0;
        chk("ifu_ar_hs", hs, 1'b1);
    endtask

    task automatic lsu_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
        bit hs = 1'b0;
        int k  = 0;
        q_lsu.push_back({d, r});
        lsu_if.araddr  = a;
        lsu_if.arvalid = 1'b1;
        while (!hs && k < 60) begin
            @(negedge clock); hs = lsu_if.arready;
            @(posedge clock); #1; k++;
        end
        lsu_if.arvalid = 1'b0;
        chk("lsu_ar_hs", hs, 1'b1);
    endtask

    task automatic lsu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                             input int lead);
        bit awd = 1'b0, wd = 1'b0, ha, hw;
        int k = 0;
        q_b.push_back(2'b00);
        lsu_if.wdata  = d;
        lsu_if.wstrb  = st;
        lsu_if.wvalid = 1'b1;
        repeat (lead) begin @(posedge clock); #1; end
        lsu_if.awaddr  = a;
        lsu_if.awvalid = 1'b1;
        while (!(awd && wd) && k < 60) begin
            @(negedge clock);
            ha = lsu_if.awvalid & lsu_if.awready;
            hw = lsu_if.wvalid & lsu_if.wready;
            @(posedge clock); #1; k++;
            if (ha) begin lsu_if.awvalid = 1'b0; awd = 1'b1; end
            if (hw) begin lsu_if.wvalid = 1'b0; wd = 1'b1; end
        end
        lsu_if.awvalid = 1'b0;
        lsu_if.wvalid  = 1'b0;
        chk("lsu_w_hs", {awd, wd}, 2'b11);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((q_ifu.size() + q_lsu.size() + q_b.size() != 0 || grant != 2'b00) && k < 100) begin
            @(posedge clock); #1; k++;
        end
        chk("drain_timeout", k >= 100, 1'b0);
        repeat (2) @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] outs();
        return {ifu_if.arready, ifu_if.rvalid, lsu_if.arready, lsu_if.rvalid, lsu_if.awready,
                lsu_if.wready, lsu_if.bvalid, s_if.arvalid, s_if.awvalid, s_if.wvalid,
                s_if.rready, s_if.bready, grant, timeout_err, 1'b0};
    endfunction

    initial begin
        int a0, w0, b0, q0;
        bit hs;
        reset = 1'b0;
        ifu_if.arvalid = 0; ifu_if.araddr = 0; ifu_if.rready = 1;
        ifu_if.awvalid = 0; ifu_if.awaddr = 0; ifu_if.wvalid = 0;
        ifu_if.wdata = 0; ifu_if.wstrb = 0; ifu_if.bready = 1;
        lsu_if.arvalid = 0; lsu_if.araddr = 0; lsu_if.rready = 1;
        lsu_if.awvalid = 0; lsu_if.awaddr = 0; lsu_if.wvalid = 0;
        lsu_if.wdata = 0; lsu_if.wstrb = 0; lsu_if.bready = 1;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outputs", outs(), 16'h0);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;

        // First tie after reset goes to the LSU
        q_g.push_back(2'b10); q_g.push_back(2'b01);
        fork
            ifu_read(32'h8000_0020, 32'hA5A5_0001, 2'b00);
            lsu_read(32'h8000_0040, 32'h1111_2222, 2'b00);
        join
        wait_idle();

        q0 = n_lsu_act;
        q_g.push_back(2'b01);
        ifu_read(32'h8000_0010, 32'h1234_5678, 2'b00);
        wait_idle();
        chk("ifu_rd_lsu_quiet", n_lsu_act - q0, 0);
        chk("ifu_rd_grant_idle", grant, 2'b00);

        a0 = n_aw; w0 = n_w;
        q_g.push_back(2'b10);
        lsu_write(32'h8000_0100, 32'hDEAD_BEEF, 4'h3, 2);
        wait_idle();
        chk("wr_aw_cnt", n_aw - a0, 1);
        chk("wr_w_cnt", n_w - w0, 1);
        chk("wr_wdata", sl_wdata, 32'hDEAD_BEEF);
        chk("wr_wstrb", sl_wstrb, 4'h3);
        chk("wr_grant_idle", grant, 2'b00);

        // Last owner is now the LSU, so this tie goes to the IFU
        q_g.push_back(2'b01); q_g.push_back(2'b10);
        fork
            ifu_read(32'h8000_0040, 32'h1111_2222, 2'b00);
            lsu_read(32'h8000_0020, 32'hA5A5_0001, 2'b00);
        join
        wait_idle();

        b0 = n_b;
        q_g.push_back(2'b10); q_g.push_back(2'b10);
        fork
            lsu_write(32'h8000_0200, 32'hCAFE_F00D, 4'hF, 0);
            lsu_read(32'h8000_0030, 32'h0BAD_CAFE, 2'b00);
        join
        wait_idle();
        chk("wr_before_rd", ar_bcnt, b0 + 1);

        sl_hang = 1'b1;
        q_g.push_back(2'b01);
        ifu_read(32'h8000_0010, 32'h0, 2'b10);
        wait_idle();
        sl_hang = 1'b0;
        chk("wdog_pulses", n_terr, 1);
        chk("wdog_cycles", t_terr - t_g01, 8);
        q_g.push_back(2'b01);
        ifu_read(32'h8000_0010, 32'h1234_5678, 2'b00);
        wait_idle();

        // Reset while LSU_WR holds an accepted AW and waits for W
        q_g.push_back(2'b10);
        lsu_if.awaddr = 32'h8000_0300; lsu_if.awvalid = 1'b1;
        hs = 1'b0;
        for (int k = 0; k < 60 && !hs; k++) begin
            @(negedge clock); hs = lsu_if.awready;
            @(posedge clock); #1;
        end
        lsu_if.awvalid = 1'b0;
        chk("mid_aw_hs", hs, 1'b1);
        @(posedge clock); #1;
        chk("mid_pre_grant", grant, 2'b10);
        @(negedge clock); reset = 1'b0;
        #1;
        chk("mid_reset_outputs", outs(), 16'h0);
        repeat (2) @(posedge clock);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        q_g.push_back(2'b10); q_g.push_back(2'b01);
        fork
            ifu_read(32'h8000_0020, 32'hA5A5_0001, 2'b00);
            lsu_read(32'h8000_0040, 32'h1111_2222, 2'b00);
        join
        wait_idle();

        chk("queues_empty", q_ifu.size() + q_lsu.size() + q_b.size() + q_g.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1);
    end
endmodule
